// File: rtl/vcore_dec_disp_q.sv
// Decode-to-dispatch skid queue: DEPTH-entry circular FIFO with valid/ready
// on both sides, synchronous flush, occupancy, almost-full and high-water mark.

package vcore_dec_disp_pkg;
    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [10:0] imm;
    } vcore_dec_disp_t;
endpackage

module vcore_dec_disp_q #(
    parameter  int DEPTH     = 2,
    parameter  int DATA_W    = $bits(vcore_dec_disp_pkg::vcore_dec_disp_t),
    parameter  int AFULL_LVL = DEPTH - 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic [CNT_W-1:0]  max_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              push, pop;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full queue still accepts when the head leaves in the same cycle.
    assign ready_out   = ~flush & ((count_q != CNT_W'(DEPTH)) | ready_in);
    assign valid_out   = (count_q != '0);
    assign push        = valid_in & ready_out;
    assign pop         = valid_out & ready_in;
    assign data_out    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign max_count   = max_q;
    assign almost_full = (count_q >= CNT_W'(AFULL_LVL));

    // Next-state for occupancy, pointers and high-water mark.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            // A concurrent pop is simply absorbed by the reset of the pointers.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    // Control state; reset clears everything except the payload storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            max_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            max_q    <= max_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage: unreset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

endmodule
